demux_rr_sched: RTL and testbench

Round-robin channel scheduler that sits directly upstream of the 1:4 structural demux and drives its select lines `S2`, `S1` and data input `A`. Up to four consumers request a slot. The scheduler grants one at a time in round-robin order and steers a serial bit stream to the granted demux output for a fixed burst length. `A` is forced low while the select lines change, so the demux never glitches data onto a non-granted output.

---
 rtl/demux_rr_sched_if.sv | 22 ++
 rtl/demux_rr_sched.sv | 96 +++++++++
 tb/tb_demux_rr_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/demux_rr_sched_if.sv
// Handshake/bus bundle between the round-robin scheduler and its requesters
// plus the downstream 1:4 demux (select lines and data input).
interface demux_rr_sched_if;
    logic [3:0] req;
    logic       data_in;
    logic       S2;
    logic       S1;
    logic       A;
    logic [3:0] grant;
    logic       busy;
    logic       done;

    modport master (
        output req, data_in,
        input  S2, S1, A, grant, busy, done
    );

    modport slave (
        input  req, data_in,
        output S2, S1, A, grant, busy, done
    );
endinterface

// File: rtl/demux_rr_sched.sv
// Round-robin scheduler driving a 1:4 demux. Grants one channel per burst and
// holds A low whenever the select lines could be moving.
module demux_rr_sched #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input logic             clk,
    input logic             rst_n,
    demux_rr_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, ACTIVE, GAP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       ptr;
    logic [1:0]       gch;
    logic [1:0]       win;
    logic [1:0]       idx;
    logic             win_vld;
    logic             s2_q, s1_q, a_q, busy_q, done_q;
    logic [3:0]       grant_q;

    // Walk offsets from 3 down to 0 so the smallest offset from ptr wins.
    always_comb begin
        win     = ptr;
        win_vld = 1'b0;
        idx     = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (bus.req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= 2'd0;
            gch     <= 2'd0;
            s2_q    <= 1'b0;
            s1_q    <= 1'b0;
            a_q     <= 1'b0;
            grant_q <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    a_q <= 1'b0;
                    if (win_vld) begin
                        state        <= SETTLE;
                        {s2_q, s1_q} <= win;
                        gch          <= win;
                        busy_q       <= 1'b1;
                    end
                end
                SETTLE: begin
                    state   <= ACTIVE;
                    cnt     <= CNT_W'(HOLD_CYCLES);
                    grant_q <= 4'b0001 << gch;
                    a_q     <= bus.data_in;
                end
                ACTIVE: begin
                    // Burst ends on the last counted cycle or when the granted requester drops.
                    if (cnt == CNT_W'(1) || !bus.req[gch]) begin
                        state   <= GAP;
                        cnt     <= '0;
                        grant_q <= 4'b0000;
                        a_q     <= 1'b0;
                        done_q  <= 1'b1;
                        ptr     <= gch + 2'd1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        a_q <= bus.data_in;
                    end
                end
                GAP: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.S2    = s2_q;
    assign bus.S1    = s1_q;
    assign bus.A     = a_q;
    assign bus.grant = grant_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_demux_rr_sched.sv
// Directed bench for demux_rr_sched: reset, single grant, payload, fairness,
// abort, reset mid-burst and late requester.
module tb_demux_rr_sched;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    demux_rr_sched_if bus();

    demux_rr_sched #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Observation vector: {S2,S1,A,grant[3:0],busy,done}
    function automatic logic [8:0] obs();
        return {bus.S2, bus.S1, bus.A, bus.grant, bus.busy, bus.done};
    endfunction

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_g [5];
    logic [3:0] seen_g [5];
    int         seen_t [5];
    int         n;
    logic [3:0] prev_g;

    initial begin
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        bus.req     = 4'b0000;
        bus.data_in = 1'b0;
        #2;
        chk("reset_state", 16'(obs()), 16'(9'b00_0_0000_00));
        #10 rst_n = 1'b1;
        step();
        chk("idle_no_req", 16'(obs()), 16'(9'b00_0_0000_00));

        // Single request on ch2
        bus.req = 4'b0100; bus.data_in = 1'b1;
        step(); chk("single_settle", 16'(obs()), 16'(9'b10_0_0000_10));
        for (int i = 0; i < 4; i++) begin
            step(); chk($sformatf("single_active%0d", i), 16'(obs()), 16'(9'b10_1_0100_10));
        end
        step(); chk("single_gap", 16'(obs()), 16'(9'b10_0_0000_11));
        bus.req = 4'b0000;
        step(); chk("single_idle", 16'(obs()), 16'(9'b10_0_0000_00));
        step(); chk("single_idle_hold", 16'(obs()), 16'(9'b10_0_0000_00));

        // Payload on ch3, pattern 1,0,1,1
        bus.req = 4'b1000;
        step(); chk("pay_settle", 16'(obs()), 16'(9'b11_0_0000_10));
        bus.data_in = 1'b1;
        step(); chk("pay_a0", 16'(obs()), 16'(9'b11_1_1000_10));
        bus.data_in = 1'b0;
        step(); chk("pay_a1", 16'(obs()), 16'(9'b11_0_1000_10));
        bus.data_in = 1'b1;
        step(); chk("pay_a2", 16'(obs()), 16'(9'b11_1_1000_10));
        bus.data_in = 1'b1;
        step(); chk("pay_a3", 16'(obs()), 16'(9'b11_1_1000_10));
        step(); chk("pay_gap", 16'(obs()), 16'(9'b11_0_0000_11));
        bus.req = 4'b0000;
        step(); chk("pay_idle", 16'(obs()), 16'(9'b11_0_0000_00));

        // Fairness: all four requesting, pointer back at ch0
        bus.data_in = 1'b0;
        bus.req     = 4'b1111;
        n = 0; prev_g = 4'b0000;
        for (int c = 0; c < 60 && n < 5; c++) begin
            step();
            if (prev_g == 4'b0000 && bus.grant != 4'b0000) begin
                seen_g[n] = bus.grant;
                seen_t[n] = c;
                n++;
            end
            prev_g = bus.grant;
        end
        chk("fair_count", 16'(n), 16'(5));
        for (int i = 0; i < n; i++) begin
            chk($sformatf("fair_grant%0d", i), 16'(seen_g[i]), 16'(exp_g[i]));
            if (i > 0) chk($sformatf("fair_period%0d", i), 16'(seen_t[i] - seen_t[i-1]), 16'(7));
        end
        begin
            int b = 0;
            while (bus.busy && b < 20) begin step(); b++; end
            chk("fair_drain", 16'(bus.busy), 16'(0));
        end

        // Abort on ch1: request dropped at the second in-ACTIVE edge
        bus.req = 4'b0010;
        step(); chk("abort_settle", 16'(obs()), 16'(9'b01_0_0000_10));
        step(); chk("abort_active0", 16'(obs()), 16'(9'b01_0_0010_10));
        step(); chk("abort_active1", 16'(obs()), 16'(9'b01_0_0010_10));
        bus.req = 4'b0000;
        step(); chk("abort_gap", 16'(obs()), 16'(9'b01_0_0000_11));
        step(); chk("abort_idle", 16'(obs()), 16'(9'b01_0_0000_00));
        bus.req = 4'b1111;
        step(); chk("post_abort_settle", 16'(obs()), 16'(9'b10_0_0000_10));
        step(); chk("post_abort_active0", 16'(obs()), 16'(9'b10_0_0100_10));
        step(); chk("post_abort_active1", 16'(obs()), 16'(9'b10_0_0100_10));

        // Asynchronous reset mid-burst
        #2 rst_n = 1'b0;
        #1 chk("mid_reset", 16'(obs()), 16'(9'b00_0_0000_00));
        #2 rst_n = 1'b1;
        step(); chk("rst_settle_ch0", 16'(obs()), 16'(9'b00_0_0000_10));
        step(); chk("rst_grant_ch0", 16'(obs()), 16'(9'b00_0_0001_10));

        // Late requester: ch3 rises mid-burst, ch0 drops in GAP
        bus.req = 4'b0001;
        step(); chk("late_active1", 16'(obs()), 16'(9'b00_0_0001_10));
        bus.req = 4'b1001;
        step(); chk("late_active2", 16'(obs()), 16'(9'b00_0_0001_10));
        step(); chk("late_active3", 16'(obs()), 16'(9'b00_0_0001_10));
        step(); chk("late_gap", 16'(obs()), 16'(9'b00_0_0000_11));
        bus.req = 4'b1000;
        step(); chk("late_idle", 16'(obs()), 16'(9'b00_0_0000_00));
        step(); chk("late_settle", 16'(obs()), 16'(9'b11_0_0000_10));
        step(); chk("late_grant_ch3", 16'(obs()), 16'(9'b11_0_1000_10));
        bus.req = 4'b0000;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
